// File: rtl/env_sched_pkg.sv
// Shared constants, FSM state type and envelope table contents for env_sched.
package env_sched_pkg;

    localparam int CLK_FREQ      = 50_000_000;
    localparam int PCM_QUANT     = 16;
    localparam int ENVELOPE_FREQ = CLK_FREQ / 65536;
    localparam int DEF_ENV_LEN   = 3 * ENVELOPE_FREQ;

    // Width of the per-voice time index.
    localparam int TW = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Envelope curve: a linear ramp, word[i] = 16*i + 1.
    function automatic logic [PCM_QUANT-1:0] env_table_word(input logic [TW-1:0] idx);
        return (PCM_QUANT'(idx) << 4) + PCM_QUANT'(1);
    endfunction

endpackage

// File: rtl/env_sched_rom.sv
// Envelope table ROM with a registered read (one cycle of latency).
module env_rom
    import env_sched_pkg::*;
#(
    parameter int DEPTH = DEF_ENV_LEN,
    parameter int AW    = 12,
    parameter int DW    = PCM_QUANT
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic [TW-1:0] idx;

    // Clamp to the last entry so a non-power-of-two depth never reads past the end.
    always_comb begin
        idx = TW'(addr);
        if (idx > TW'(DEPTH - 1)) begin
            idx = TW'(DEPTH - 1);
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        data <= DW'(env_table_word(idx));
    end

endmodule

// File: rtl/env_sched.sv
// Time-multiplexed envelope sequencer: one shared table ROM serves NVOICE voices.
// Each tick sweeps voices 0..NVOICE-1 through ADDR/WAIT/DATA, then one DONE cycle.
// tick and trig are single-cycle strobes; there is no back-pressure on either side.
module env_sched
    import env_sched_pkg::*;
#(
    parameter int NVOICE  = 8,
    parameter int VW      = 3,
    parameter int ENV_LEN = DEF_ENV_LEN
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          tick,
    input  logic [NVOICE-1:0]             trig,
    output logic [NVOICE*PCM_QUANT-1:0]   env_out,
    output logic                          env_valid,
    output logic [NVOICE-1:0]             active,
    output logic                          busy,
    output logic                          overrun,
    output logic [2:0]                    dbg_state
);

    localparam int            AW     = (ENV_LEN > 1) ? $clog2(ENV_LEN) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(ENV_LEN - 1);
    localparam logic [VW-1:0] V_LAST = VW'(NVOICE - 1);

    state_e                        state_q, state_d;
    logic [VW-1:0]                 v_q, v_d;
    logic [TW-1:0]                 t_q [NVOICE];
    logic [TW-1:0]                 t_d [NVOICE];
    logic [NVOICE-1:0]             pend_trig_q, pend_trig_d;
    logic                          pend_tick_q, pend_tick_d;
    logic [AW-1:0]                 rom_addr_q, rom_addr_d;
    logic [NVOICE*PCM_QUANT-1:0]   env_q, env_d;
    logic                          overrun_q, overrun_d;
    logic [PCM_QUANT-1:0]          rom_data;

    env_rom #(
        .DEPTH (ENV_LEN),
        .AW    (AW),
        .DW    (PCM_QUANT)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr_q),
        .data (rom_data)
    );

    // Next-state logic for the sweep FSM, pending requests and per-voice state.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        t_d         = t_q;
        pend_trig_d = pend_trig_q | trig;
        pend_tick_d = pend_tick_q;
        rom_addr_d  = rom_addr_q;
        env_d       = env_q;
        overrun_d   = overrun_q;

        // A tick arriving mid-sweep is held one deep; a second one is lost.
        if (tick && (state_q != ST_IDLE)) begin
            if (pend_tick_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_tick_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick || pend_tick_q) begin
                    state_d     = ST_ADDR;
                    v_d         = '0;
                    pend_tick_d = 1'b0;
                end
            end
            ST_ADDR: begin
                rom_addr_d = pend_trig_q[v_q] ? '0 : t_q[v_q][AW-1:0];
                // A retrigger landing in its own slot is kept for the next sweep.
                pend_trig_d[v_q] = trig[v_q];
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                env_d[int'(v_q)*PCM_QUANT +: PCM_QUANT] = rom_data;
                t_d[v_q] = (TW'(rom_addr_q) == T_LAST) ? T_LAST : TW'(rom_addr_q) + TW'(1);
                if (v_q == V_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    v_d     = v_q + VW'(1);
                    state_d = ST_ADDR;
                end
            end
            ST_DONE: begin
                if (tick || pend_tick_q) begin
                    state_d     = ST_ADDR;
                    v_d         = '0;
                    pend_tick_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; clr aborts any sweep and silences every voice.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            v_q         <= '0;
            for (int i = 0; i < NVOICE; i++) begin
                t_q[i] <= T_LAST;
            end
            pend_trig_q <= '0;
            pend_tick_q <= 1'b0;
            rom_addr_q  <= '0;
            env_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            t_q         <= t_d;
            pend_trig_q <= pend_trig_d;
            pend_tick_q <= pend_tick_d;
            rom_addr_q  <= rom_addr_d;
            env_q       <= env_d;
            overrun_q   <= overrun_d;
        end
    end

    // A voice is active until its time index reaches the last table entry.
    always_comb begin
        for (int i = 0; i < NVOICE; i++) begin
            active[i] = (t_q[i] != T_LAST);
        end
    end

    assign env_out   = env_q;
    assign env_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: doc/env_sched.md
Name: env_sched

Overview:
- Time-multiplexed envelope sequencer: one envelope table ROM is shared by NVOICE voices.
- On each envelope-rate tick, it sweeps all voices in order. For each voice it reads the table at that voice's time index, latches the result, then advances the index, saturating at the end.
- Per-voice retrigger requests are latched and applied in that voice's slot.
- Sits between the note/voice control logic and the per-voice amplitude multipliers.

Parameters:
- NVOICE, 8, number of voices; must be at least 1.
- VW, 3, voice-index width; must satisfy 2**VW >= NVOICE.
- ENV_LEN, 3*`ENVELOPE_FREQ, table depth; the last index is ENV_LEN-1; must be at most 65536.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- tick  in  1  one-cycle strobe at ENVELOPE_FREQ; starts a sweep.
- trig  in  NVOICE  per-voice retrigger pulses; bit v restarts voice v.
- env_out  out  NVOICE*`PCM_QUANT  per-voice envelope values, flat; voice v occupies bits [v*`PCM_QUANT +: `PCM_QUANT].
- env_valid  out  1  one-cycle pulse when a sweep completes.
- active  out  NVOICE  bit v = 1 while t[v] != ENV_LEN-1.
- busy  out  1  high while the FSM is not IDLE.
- overrun  out  1  sticky flag: a tick was dropped.

Behaviour:
- Reset (clr=1 at a posedge), overriding everything:
  - state = IDLE, voice counter = 0, all t[v] = ENV_LEN-1 (voices silent).
  - pend_trig = 0, pend_tick = 0, env_out = 0, env_valid = 0, overrun = 0.
  - clr asserted mid-sweep aborts the sweep; nothing partial survives.
- Internal state:
  - t[v]: 16-bit time index per voice.
  - pend_trig[v]: sticky; set by trig[v].
  - pend_tick: one-deep tick latch.
- FSM states: IDLE, ADDR, WAIT, DATA, DONE.
  - IDLE: if tick or pend_tick, go to ADDR with v = 0 and clear pend_tick.
  - ADDR: a = pend_trig[v] ? 0 : t[v]. Register rom_addr <= a. Clear pend_trig[v] unless trig[v] is high in this same cycle; that new request stays pending for the next sweep. Go to WAIT.
  - WAIT: the ROM samples rom_addr. Go to DATA.
  - DATA: rom_data is valid.
    - env_out[v] <= rom_data.
    - t[v] <= (a == ENV_LEN-1) ? ENV_LEN-1 : a+1.
    - Go to ADDR with v+1, or to DONE if v == NVOICE-1.
  - DONE: env_valid = 1 for exactly this cycle. Next state is ADDR (v = 0) if pend_tick or tick, else IDLE; pend_tick is cleared on the ADDR path.
- Timing: if tick is sampled at edge k in IDLE:
  - env_out[v] updates at edge k+3(v+1).
  - env_valid is high in the cycle after edge k+3*NVOICE.
  - A sweep occupies 3*NVOICE+1 cycles.
- Tick while busy (any non-IDLE state, including DONE):
  - Sets pend_tick.
  - If pend_tick is already set, the tick is dropped and overrun <= 1. Only clr clears overrun.
- trig[v] in any state except reset sets pend_trig[v]. Multiple trig pulses before service collapse into one.
- A retriggered voice outputs table[0] in its slot; t[v] becomes 1.
- Saturation: once t[v] = ENV_LEN-1, the voice keeps outputting table[ENV_LEN-1] and active[v] = 0.
- Arithmetic:
  - t[v] is 16-bit unsigned and never wraps.
  - rom_addr width is $clog2(ENV_LEN).
  - env_out values are the ROM words unmodified.
- env_out holds its value between sweeps. busy = (state != IDLE).

Decomposition:
- def.v:
  - Owns `PCM_QUANT and `CLK_FREQ.
  - Moves `ENVELOPE_FREQ here as (`CLK_FREQ/65536) and adds `ENV_LEN as 3*`ENVELOPE_FREQ.
  - Adds FSM state encodings as `define constants.
- Sub-module env_rom(clk, addr, data):
  - Holds `PCM_QUANT-wide words, ENV_LEN deep.
  - Loaded by $readmemh("env_table.hex").
  - Registered read, 1-cycle latency.
  - Instantiated once inside env_sched.

Test Plan:
- Use NVOICE=4 and ENV_LEN=16. Load env_table.hex with entry[i] = 16*i+1.
1. Reset, then tick: busy goes high; every env_out[v] = 241 (entry 15); active = 0; env_valid pulses exactly 13 cycles after the tick edge; busy then drops.
2. trig[2] then tick: env_out[2] = 1, other voices = 241, active = 4'b0100. Second tick: env_out[2] = 17.
3. trig[0], then 20 ticks: env_out[0] steps 1, 17, … 241, then holds 241; active[0] falls after the 15th sweep.
4. Tick at cycle 0 and at cycle 4 (mid-sweep): the second sweep starts right after DONE with no IDLE cycle; overrun = 0. Ticks at 0, 4 and 6: overrun = 1 and exactly two env_valid pulses.
5. trig[1] asserted in voice 1's ADDR cycle with pend_trig[1] already set: this sweep gives env_out[1] = 1; the next sweep gives env_out[1] = 1 again (retrigger kept).
6. clr asserted in voice 2's WAIT state: next cycle all outputs = 0, state IDLE, pending cleared. A subsequent tick gives all env_out = 241.
